// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op codes and FSM state encoding shared by seq_alu and its core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_core.sv
// ============================================================================
// seq_alu_core : combinational add/sub/logic/compare slice with CF/OF/ZF.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             cf,
  output logic             of,
  output logic             zf
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             lt;

  always_comb begin
    // SLT and EQ share the subtractor so their flags match SUB
    sub_mode = (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
    b_eff    = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt       = sum[WIDTH-1] ^ ovf;

    res = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = ovf;
      end
      OP_NOT: res = ~a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLT: begin
        res = {{(WIDTH-1){1'b0}}, lt};
        cf  = sum[WIDTH];
        of  = ovf;
      end
      OP_EQ: begin
        res = {{(WIDTH-1){1'b0}}, (a == b)};
        cf  = sum[WIDTH];
        of  = ovf;
      end
      default: ;
    endcase
    zf = (res == '0);
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : WIDTH-bit sequential ALU with start/busy/done handshake,
//           bit-serial shifts and shift-add multiply.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             CF,
  output logic             OF,
  output logic             ZF
);

  localparam int CW = SHW + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cf_q, cf_d;
  logic               of_q, of_d;
  logic               zf_q, zf_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   core_res;
  logic               core_cf, core_of, core_zf;
  logic [WIDTH-1:0]   step_val;
  logic               step_out;
  logic [2*WIDTH-1:0] mul_sum;
  logic               is_shift, is_mul;
  logic [SHW-1:0]     amt;

  seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .op  (op),
    .a   (x),
    .b   (y),
    .res (core_res),
    .cf  (core_cf),
    .of  (core_of),
    .zf  (core_zf)
  );

  // One iteration of the running shift, or the multiplier shift for MUL
  always_comb begin
    step_val = work_q;
    step_out = 1'b0;
    case (op_q)
      OP_SLL: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        step_out = work_q[WIDTH-1];
      end
      OP_SRL: begin
        step_val = {1'b0, work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
      OP_SRA: begin
        step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
      OP_MUL: step_val = {1'b0, work_q[WIDTH-1:1]};
      default: ;
    endcase
    mul_sum = prod_q + (work_q[0] ? mcand_q : '0);
  end

  always_comb begin
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    is_mul   = (op == OP_MUL);
    amt      = y[SHW-1:0];

    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    work_d  = work_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    res_d   = res_q;
    cf_d    = cf_q;
    of_d    = of_q;
    zf_d    = zf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            state_d = ST_RUN;
            count_d = CW'(WIDTH);
            op_d    = op;
            work_d  = y;
            mcand_d = {{WIDTH{1'b0}}, x};
            prod_d  = '0;
          end else if (is_shift && (amt != '0)) begin
            state_d = ST_RUN;
            count_d = {1'b0, amt};
            op_d    = op;
            work_d  = x;
          end else if (is_shift) begin
            res_d  = x;
            cf_d   = 1'b0;
            of_d   = 1'b0;
            zf_d   = (x == '0);
            done_d = 1'b1;
          end else begin
            res_d  = core_res;
            cf_d   = core_cf;
            of_d   = core_of;
            zf_d   = core_zf;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        count_d = count_q - CW'(1);
        work_d  = step_val;
        mcand_d = mcand_q << 1;
        prod_d  = mul_sum;
        if (count_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (op_q == OP_MUL) begin
            res_d = mul_sum[WIDTH-1:0];
            cf_d  = (mul_sum[2*WIDTH-1:WIDTH] != '0);
            of_d  = (mul_sum[2*WIDTH-1:WIDTH] != '0);
            zf_d  = (mul_sum[WIDTH-1:0] == '0);
          end else begin
            res_d = step_val;
            cf_d  = step_out;
            of_d  = 1'b0;
            zf_d  = (step_val == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= '0;
      work_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      work_q  <= work_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign res  = res_q;
  assign CF   = cf_q;
  assign OF   = of_q;
  assign ZF   = zf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : directed self-checking bench for seq_alu at WIDTH=8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [7:0] x, y;
  logic       busy, done, cf, of, zf;
  logic [7:0] res;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .CF    (cf),
    .OF    (of),
    .ZF    (zf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one start pulse and waits (bounded) for done; lat=0 means timeout
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_vec(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input int exp_busy,
                        input logic [7:0] exp_res, input logic [2:0] exp_flags);
    int lat, bcnt;
    run_op(o, a, b, lat, bcnt);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bcnt, exp_busy);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_flags"}, {cf, of, zf}, exp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, dones;
    rst = 1'b1; start = 1'b0; op = 4'd0; x = 8'h00; y = 8'h00;
    repeat (3) @(negedge clk);
    check("reset", {busy, done, cf, of, zf, res}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle", {busy, done, cf, of, zf, res}, 32'h0);

    // flags are {CF, OF, ZF}
    do_vec("add_ovf",  4'd0,  8'h7F, 8'h01, 1, 0, 8'h80, 3'b010);
    do_vec("add_cry",  4'd0,  8'hFF, 8'h01, 1, 0, 8'h00, 3'b101);
    do_vec("sub_eq",   4'd1,  8'h05, 8'h05, 1, 0, 8'h00, 3'b101);
    do_vec("slt",      4'd6,  8'hFE, 8'h01, 1, 0, 8'h01, 3'b100);
    do_vec("eq",       4'd7,  8'h3C, 8'h3C, 1, 0, 8'h01, 3'b100);
    do_vec("xor",      4'd5,  8'hA5, 8'hFF, 1, 0, 8'h5A, 3'b000);
    do_vec("not",      4'd2,  8'hFF, 8'h00, 1, 0, 8'h00, 3'b001);
    do_vec("sra3",     4'd10, 8'h90, 8'h03, 4, 3, 8'hF2, 3'b000);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    do_vec("sll0",     4'd8,  8'h81, 8'h08, 1, 0, 8'h81, 3'b000);
    do_vec("srl1",     4'd9,  8'h81, 8'h01, 2, 1, 8'h40, 3'b100);
    do_vec("sll2",     4'd8,  8'hC1, 8'h02, 3, 2, 8'h04, 3'b100);
    do_vec("mul_big",  4'd11, 8'h10, 8'h10, 9, 8, 8'h00, 3'b111);
    do_vec("mul_sq",   4'd11, 8'h0F, 8'h0F, 9, 8, 8'hE1, 3'b000);
    run_op(4'd12, 8'h12, 8'h34, lat, bcnt);
    check("op12_lat", lat, 1);
    check("op12_res", res, 8'h00);

    // ADD pulse during MUL must be ignored
    @(negedge clk);
    start = 1'b1; op = 4'd11; x = 8'h03; y = 8'h05;
    dones = 0; lat = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; op = 4'd0; x = 8'h11; y = 8'h22;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (lat == 0) lat = k;
      end
    end
    check("mul_ign_lat", lat, 9);
    check("mul_ign_dones", dones, 1);
    check("mul_ign_res", res, 8'h0F);

    // reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; op = 4'd11; x = 8'h10; y = 8'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", {busy, done, cf, of, zf, res}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after", {busy, done}, 2'b00);
    do_vec("and",      4'd3,  8'hF0, 8'h3C, 1, 0, 8'h30, 3'b000);

    // start held high: back-to-back single-cycle ops
    @(negedge clk);
    start = 1'b1; op = 4'd0; x = 8'h01; y = 8'h01;
    @(negedge clk);
    check("b2b_1", {done, res}, {1'b1, 8'h02});
    y = 8'h02;
    @(negedge clk);
    check("b2b_2", {done, res}, {1'b1, 8'h03});
    start = 1'b0;
    @(negedge clk);
    check("b2b_end", {done, res}, {1'b0, 8'h03});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
